// File: rtl/sap_1_controller_sequencer_pkg.sv
// sap_1_controller_sequencer_pkg: opcodes, control-word layout, fixed control words and ring states
package sap_1_controller_sequencer_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int CON_CP    = 11;
  localparam int CON_EP    = 10;
  localparam int CON_LMBAR = 9;
  localparam int CON_CEBAR = 8;
  localparam int CON_LIBAR = 7;
  localparam int CON_EIBAR = 6;
  localparam int CON_LABAR = 5;
  localparam int CON_EA    = 4;
  localparam int CON_SU    = 3;
  localparam int CON_EU    = 2;
  localparam int CON_LBBAR = 1;
  localparam int CON_LOBAR = 0;
  localparam logic [11:0] CON_NOP    = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEM_T4 = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;
endpackage

// File: rtl/sap_1_ring_counter.sv
// sap_1_ring_counter: one-hot T1..T6 ring with hold and illegal-state recovery
module sap_1_ring_counter
  import sap_1_controller_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       hold_in,
  output logic [5:0] t_state_out
);
  logic [5:0] r_ring;
  logic [5:0] w_next;
  always_ff @(posedge CLK) r_ring <= w_next;
  always_comb begin
    w_next = {r_ring[4:0], r_ring[5]};
    if (hold_in) w_next = r_ring;
    if (CLR || !$onehot(r_ring)) w_next = T1;
  end
  assign t_state_out = r_ring;
endmodule

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 control word decode from ring state and opcode, with sticky halt
module sap_1_controller_sequencer
  import sap_1_controller_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  opcode_in,
  output logic [11:0] con_out,
  output logic [5:0]  t_state_out,
  output logic        halt_out
);
  logic        r_halted;
  logic        w_halt;
  logic [5:0]  w_ring;
  logic [11:0] w_con;
  logic        w_mem_op;
  sap_1_ring_counter u_ring (
    .CLK         (CLK),
    .CLR         (CLR),
    .hold_in     (w_halt),
    .t_state_out (w_ring)
  );
  // HLT is recognised in T4 itself so the ring holds at T4 on the same edge that sets r_halted
  assign w_halt   = r_halted || (w_ring == T4 && opcode_in == OP_HLT);
  assign w_mem_op = opcode_in == OP_LDA || opcode_in == OP_ADD || opcode_in == OP_SUB;
  always_ff @(posedge CLK)
    if (CLR) r_halted <= 1'b0;
    else if (w_halt) r_halted <= 1'b1;
  always_comb begin
    w_con = CON_NOP;
    case (w_ring)
      T1: w_con = CON_T1;
      T2: w_con = CON_T2;
      T3: w_con = CON_T3;
      T4: w_con = opcode_in == OP_OUT ? CON_OUT_T4 : w_mem_op ? CON_MEM_T4 : CON_NOP;
      T5: w_con = opcode_in == OP_LDA ? CON_LDA_T5 :
                  (opcode_in == OP_ADD || opcode_in == OP_SUB) ? CON_ALU_T5 : CON_NOP;
      T6: w_con = opcode_in == OP_ADD ? CON_ADD_T6 : opcode_in == OP_SUB ? CON_SUB_T6 : CON_NOP;
      default: w_con = CON_NOP;
    endcase
    if (CLR || w_halt) w_con = CON_NOP;
  end
  assign con_out     = w_con;
  assign t_state_out = w_ring;
  assign halt_out    = !CLR && w_halt;
endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb_sap_1_controller_sequencer: directed + random stimulus against a step-index reference model
module tb_sap_1_controller_sequencer;
  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [3:0]  opcode_in = 4'b0000;
  logic [11:0] con_out;
  logic [5:0]  t_state_out;
  logic        halt_out;
  int checks = 0;
  int errors = 0;
  int k = 0;
  bit m_halted = 1'b0;
  bit known = 1'b0;

  sap_1_controller_sequencer dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .opcode_in   (opcode_in),
    .con_out     (con_out),
    .t_state_out (t_state_out),
    .halt_out    (halt_out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] exp_con(int step, logic [3:0] op, bit hl, bit clr);
    logic [11:0] t4 [16];
    logic [11:0] t5 [16];
    logic [11:0] t6 [16];
    for (int i = 0; i < 16; i++) begin
      t4[i] = 12'h3E3;
      t5[i] = 12'h3E3;
      t6[i] = 12'h3E3;
    end
    t4[0] = 12'h1A3; t5[0] = 12'h2C3;
    t4[1] = 12'h1A3; t5[1] = 12'h2E1; t6[1] = 12'h3C7;
    t4[2] = 12'h1A3; t5[2] = 12'h2E1; t6[2] = 12'h3CF;
    t4[14] = 12'h3F2;
    if (clr || hl || (step == 3 && op == 4'hF)) return 12'h3E3;
    case (step)
      0: return 12'h5E3;
      1: return 12'hBE3;
      2: return 12'h263;
      3: return t4[op];
      4: return t5[op];
      default: return t6[op];
    endcase
  endfunction

  task automatic cmp(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit clr, logic [3:0] op);
    @(negedge CLK);
    CLR = clr;
    opcode_in = op;
    #1;
  endtask

  task automatic check_model();
    bit exp_halt;
    exp_halt = !CLR && (m_halted || (known && k == 3 && opcode_in == 4'hF));
    cmp("con", con_out, exp_con(k, opcode_in, m_halted, CLR));
    cmp("halt", {11'd0, halt_out}, {11'd0, exp_halt});
    if (known) cmp("tstate", {6'd0, t_state_out}, {6'd0, 6'b1 << k});
  endtask

  task automatic tick();
    bit c;
    logic [3:0] op;
    c = CLR;
    op = opcode_in;
    @(posedge CLK);
    if (c) begin
      k = 0;
      m_halted = 1'b0;
      known = 1'b1;
    end else if (m_halted || (k == 3 && op == 4'hF)) m_halted = 1'b1;
    else k = (k + 1) % 6;
  endtask

  task automatic step(bit clr, logic [3:0] op);
    drive(clr, op);
    check_model();
    tick();
  endtask

  task automatic run_instr(logic [3:0] op, logic [11:0] e4, logic [11:0] e5, logic [11:0] e6);
    for (int i = 0; i < 3; i++) step(1'b0, op);
    drive(1'b0, op); check_model(); cmp("lit_t4", con_out, e4); tick();
    drive(1'b0, op); check_model(); cmp("lit_t5", con_out, e5); tick();
    drive(1'b0, op); check_model(); cmp("lit_t6", con_out, e6); tick();
  endtask

  initial begin
    drive(1'b1, 4'h0); check_model(); cmp("rst_con", con_out, 12'h3E3); tick();
    drive(1'b1, 4'h0); check_model(); cmp("rst_t1", {6'd0, t_state_out}, 12'h001);
    cmp("rst_halt", {11'd0, halt_out}, 12'h000); tick();
    drive(1'b0, 4'h0); check_model(); cmp("fetch_t1", con_out, 12'h5E3); tick();
    drive(1'b0, 4'h0); check_model(); cmp("fetch_t2", con_out, 12'hBE3); tick();
    drive(1'b0, 4'h0); check_model(); cmp("fetch_t3", con_out, 12'h263); tick();
    step(1'b0, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'h0);
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr(4'h5, 12'h3E3, 12'h3E3, 12'h3E3);
    drive(1'b0, 4'h5); check_model(); cmp("wrap_t1", con_out, 12'h5E3); tick();
    step(1'b0, 4'h0); step(1'b0, 4'h0);
    drive(1'b0, 4'hF); check_model(); cmp("hlt_t4_con", con_out, 12'h3E3);
    cmp("hlt_t4_halt", {11'd0, halt_out}, 12'h001); tick();
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0);
    drive(1'b0, 4'h0); check_model();
    cmp("halted_t", {6'd0, t_state_out}, 12'h008);
    cmp("halted_halt", {11'd0, halt_out}, 12'h001);
    cmp("halted_con", con_out, 12'h3E3); tick();
    drive(1'b1, 4'h0); check_model(); cmp("clr_halt", {11'd0, halt_out}, 12'h000); tick();
    drive(1'b0, 4'h1); check_model(); cmp("resume_t1", con_out, 12'h5E3); tick();
    for (int i = 0; i < 3; i++) step(1'b0, 4'h1);
    drive(1'b1, 4'h1); check_model(); cmp("clr_t5_con", con_out, 12'h3E3); tick();
    drive(1'b0, 4'h1); check_model(); cmp("clr_t5_t1", {6'd0, t_state_out}, 12'h001); tick();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      int r;
      r = $urandom_range(0, 15);
      op = r < 2 ? 4'hF : r < 10 ? (r < 4 ? 4'h0 : r < 6 ? 4'h1 : r < 8 ? 4'h2 : 4'hE)
                        : 4'($urandom_range(0, 14));
      step($urandom_range(0, 29) == 0, op);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap_1_controller_sequencer.md
Name: sap_1_controller_sequencer

Overview:
Control unit for the SAP-1 computer.
- A 6-state ring counter (T1..T6) sequences fetch (T1–T3) and execute (T4–T6).
- Each cycle it emits the 12-bit SAP-1 control word that drives the PC, MAR, the 16x8 program ROM (CEbar), IR, accumulator, adder/subtracter, B register and output register.
- It decodes the IR opcode nibble and latches a sticky halt state on HLT.

Parameters:
OP_LDA, 4'b0000, load accumulator opcode
OP_ADD, 4'b0001, add opcode
OP_SUB, 4'b0010, subtract opcode
OP_OUT, 4'b1110, output opcode
OP_HLT, 4'b1111, halt opcode

Ports:
CLK  input  1  system clock; all state updates on the rising edge
CLR  input  1  synchronous reset, active-high
opcode_in  input  4  IR upper nibble; valid from the start of T4 through the end of T6
con_out  output  12  control word {Cp,Ep,LMbar,CEbar,LIbar,EIbar,LAbar,Ea,Su,Eu,LBbar,LObar}; bit 11 = Cp
t_state_out  output  6  one-hot ring state; bit0 = T1 .. bit5 = T6
halt_out  output  1  high while halted

Interface (already decided):
- One clock, CLK.
- Reset CLR is synchronous and active-high.

Behaviour:
- Inactive control word NOP = 12'h3E3: all active-low signals high, all active-high signals low.

Reset:
- CLR is sampled only on the rising edge of CLK.
- At that edge: ring <= T1 (6'b000001), halted <= 0.
- While CLR is high, con_out is forced to 12'h3E3 and halt_out to 0, independent of state.
- CLR in any state, including halted or mid-instruction, returns to T1 on the next edge.
- Sequence restarts with fetch.

Ring counter:
- Advances T1->T2->...->T6->T1 each rising edge when not halted and CLR is low.
- Always exactly one bit set.
- Any illegal encoding recovers to T1 on the next edge.

Control word:
- Combinational decode of (ring, opcode_in, halted); no added latency.
- Fetch (all opcodes):
  - T1 = 12'h5E3 (Ep, LMbar)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (CEbar, LIbar)
- LDA: T4 = 12'h1A3 (LMbar, EIbar), T5 = 12'h2C3 (CEbar, LAbar), T6 = 12'h3E3
- ADD: T4 = 12'h1A3, T5 = 12'h2E1 (CEbar, LBbar), T6 = 12'h3C7 (LAbar, Eu)
- SUB: as ADD, except T6 = 12'h3CF (LAbar, Su, Eu)
- OUT: T4 = 12'h3F2 (Ea, LObar), T5 = T6 = 12'h3E3
- Undefined opcodes (0011–1101): T4–T6 = 12'h3E3; ring continues normally.

Halt:
- HLT in T4:
  - con_out = 12'h3E3.
  - halt_out asserts combinationally during that T4.
  - halted <= 1 at the closing edge.
- While halted:
  - Ring frozen at T4.
  - con_out = 12'h3E3; CEbar stays high, so the ROM bus floats.
  - halt_out = 1.
  - opcode_in is ignored.
- Only CLR exits the halted state.
- halt_out = halted | (T4 & opcode_in == OP_HLT).

Opcode timing:
- opcode_in is only consulted in T4–T6; it is a don't-care in T1–T3.
- The IR is loaded at the T3 closing edge.

Decomposition:
Shared include file sap_1_defines.vh:
- Opcode values.
- Control-word bit indices.
- CON_NOP = 12'h3E3.
- Fetch words T1/T2/T3.

Sub-module sap_1_ring_counter (CLK, CLR, hold_in, t_state_out):
- 6-bit one-hot ring.
- Synchronous reset to T1.
- hold_in freezes the ring.
- Illegal-state recovery to T1.

The top-level module contains the opcode/state decoder and the halt register.

Test Plan:
1. Reset: CLR=1 for 2 edges, then released -> during CLR, con_out=12'h3E3 and halt_out=0; after the first edge t_state_out=6'b000001; after release con_out=12'h5E3, then 12'hBE3, then 12'h263 on successive edges.
2. LDA: opcode_in=4'b0000 from T4 -> con_out sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to T1 = 5E3.
3. ADD then SUB: T4–T6 = 1A3, 2E1, 3C7 for 4'b0001; 1A3, 2E1, 3CF for 4'b0010.
4. OUT and undefined opcode: OUT gives T4–T6 = 3F2, 3E3, 3E3; opcode 4'b0101 gives 3E3 x3 and the ring wraps to T1.
5. HLT: opcode 4'b1111 -> halt_out=1 in T4, con_out=3E3; after 10 further edges t_state_out stays 6'b001000, con_out=3E3, halt_out=1 even if opcode_in changes to 4'b0000.
6. CLR mid-operation and during halt: assert CLR in T5 of an ADD -> next edge T1, con_out=3E3 while CLR is high; assert CLR while halted -> halt_out=0, and the ring resumes at T1 after release.
